// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch/jump flush, multiply/divide busy stall,
// operand forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_unit (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic        IDuseRs,
    input  logic        IDuseRt,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic [4:0]  EXwn,
    input  logic        MEMwreg,
    input  logic        MEMm2reg,
    input  logic [4:0]  MEMwn,
    input  logic [1:0]  EXjumpType,
    input  logic        EXbranchTaken,
    input  logic        EXmdStart,
    output logic        pcWrite,
    output logic        IFIDwrite,
    output logic        IFIDflush,
    output logic        IDEXbubble,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        mdBusy,
    output logic [15:0] stallCnt
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_MDBUSY = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_mdCnt;
    logic [15:0] r_stallCnt;

    logic w_redirect;
    logic w_loadUse;
    logic w_exLoad;

    assign w_redirect = (EXjumpType == 2'b01) || (EXjumpType == 2'b10) ||
                        ((EXjumpType == 2'b11) && EXbranchTaken);
    assign w_exLoad   = EXwreg && EXm2reg && (EXwn != 5'd0);
    assign w_loadUse  = w_exLoad && ((IDuseRs && (EXwn == IDrs)) ||
                                     (IDuseRt && (EXwn == IDrt)));

    // EX-stage ALU result beats anything in MEM; register 0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       ex_wreg,
                                           input logic       ex_m2reg,
                                           input logic [4:0] ex_wn,
                                           input logic       mem_wreg,
                                           input logic       mem_m2reg,
                                           input logic [4:0] mem_wn);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_wreg && !ex_m2reg && (ex_wn != 5'd0) && (ex_wn == src))
            sel = 2'b01;
        else if (mem_wreg && (mem_wn != 5'd0) && (mem_wn == src))
            sel = mem_m2reg ? 2'b11 : 2'b10;
        return sel;
    endfunction

    assign fwdA = fwd_sel(IDrs, EXwreg, EXm2reg, EXwn, MEMwreg, MEMm2reg, MEMwn);
    assign fwdB = fwd_sel(IDrt, EXwreg, EXm2reg, EXwn, MEMwreg, MEMm2reg, MEMwn);

    always_comb begin
        pcWrite    = 1'b1;
        IFIDwrite  = 1'b1;
        IFIDflush  = 1'b0;
        IDEXbubble = 1'b0;
        if (r_state == S_MDBUSY) begin
            pcWrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXbubble = 1'b1;
        end else if (w_redirect) begin
            IFIDflush  = 1'b1;
            IDEXbubble = 1'b1;
        end else if (w_loadUse) begin
            pcWrite    = 1'b0;
            IFIDwrite  = 1'b0;
            IDEXbubble = 1'b1;
        end
    end

    assign mdBusy   = (r_state == S_MDBUSY);
    assign stallCnt = r_stallCnt;

    // mdCnt runs 3..0 inside MDBUSY, giving four stall cycles
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_RUN;
            r_mdCnt <= 2'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (EXmdStart) begin
                        r_state <= S_MDBUSY;
                        r_mdCnt <= 2'd3;
                    end
                end
                default: begin
                    if (r_mdCnt == 2'd0)
                        r_state <= S_RUN;
                    else
                        r_mdCnt <= r_mdCnt - 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_stallCnt <= 16'd0;
        else if (!pcWrite && (r_stallCnt != 16'hFFFF))
            r_stallCnt <= r_stallCnt + 16'd1;
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios, randomized traffic and
// counter saturation, all checked against a cycle-count based reference model.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  IDrs, IDrt, EXwn, MEMwn;
    logic        IDuseRs, IDuseRt, EXwreg, EXm2reg, MEMwreg, MEMm2reg;
    logic [1:0]  EXjumpType;
    logic        EXbranchTaken, EXmdStart;
    logic        pcWrite, IFIDwrite, IFIDflush, IDEXbubble, mdBusy;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stallCnt;

    int checks = 0;
    int errors = 0;

    // reference model: busy cycles still to serve, and total stalled cycles
    int md_left;
    int stall_total;
    logic       e_pc, e_ifid, e_flush, e_bub, e_busy;
    logic [1:0] e_fa, e_fb;

    pipe_hazard_unit dut (
        .clk(clk), .clrn(clrn), .IDrs(IDrs), .IDrt(IDrt), .IDuseRs(IDuseRs), .IDuseRt(IDuseRt),
        .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn), .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg),
        .MEMwn(MEMwn), .EXjumpType(EXjumpType), .EXbranchTaken(EXbranchTaken), .EXmdStart(EXmdStart),
        .pcWrite(pcWrite), .IFIDwrite(IFIDwrite), .IFIDflush(IFIDflush), .IDEXbubble(IDEXbubble),
        .fwdA(fwdA), .fwdB(fwdB), .mdBusy(mdBusy), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (EXwreg && !EXm2reg && EXwn == r) return 2'b01;
        if (MEMwreg && MEMwn == r) return MEMm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_outputs();
        logic redirect, load_use;
        redirect = (EXjumpType inside {2'b01, 2'b10}) || (EXjumpType == 2'b11 && EXbranchTaken);
        load_use = EXwreg && EXm2reg && EXwn != 0 &&
                   ((IDuseRs && EXwn == IDrs) || (IDuseRt && EXwn == IDrt));
        e_busy = (md_left > 0);
        if (e_busy)        {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
        else if (redirect) {e_pc, e_ifid, e_flush, e_bub} = 4'b1111;
        else if (load_use) {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
        else               {e_pc, e_ifid, e_flush, e_bub} = 4'b1100;
        e_fa = ref_fwd(IDrs);
        e_fb = ref_fwd(IDrt);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        model_outputs();
        chk("pcWrite", {15'd0, pcWrite}, {15'd0, e_pc});
        chk("IFIDwrite", {15'd0, IFIDwrite}, {15'd0, e_ifid});
        chk("IFIDflush", {15'd0, IFIDflush}, {15'd0, e_flush});
        chk("IDEXbubble", {15'd0, IDEXbubble}, {15'd0, e_bub});
        chk("mdBusy", {15'd0, mdBusy}, {15'd0, e_busy});
        chk("fwdA", {14'd0, fwdA}, {14'd0, e_fa});
        chk("fwdB", {14'd0, fwdB}, {14'd0, e_fb});
        chk("stallCnt", stallCnt, stall_total[15:0]);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    // one rising edge, then advance the model from the inputs seen at that edge
    task automatic tick();
        model_outputs();
        @(posedge clk);
        if (!e_pc && stall_total < 65535) stall_total++;
        if (md_left > 0)    md_left--;
        else if (EXmdStart) md_left = 4;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_in();
        {IDrs, IDrt, EXwn, MEMwn} = '0;
        {IDuseRs, IDuseRt, EXwreg, EXm2reg, MEMwreg, MEMm2reg} = '0;
        EXjumpType = 2'b00; EXbranchTaken = 1'b0; EXmdStart = 1'b0;
    endtask

    task automatic set_load_use();
        EXwreg = 1; EXm2reg = 1; EXwn = 5; IDrs = 5; IDuseRs = 1;
    endtask

    // async reset pulse between clock edges, checked before any edge arrives
    task automatic pulse_reset();
        #2 clrn = 1'b0;
        md_left = 0; stall_total = 0;
        #1 check_all();
        chk("rst_mdBusy", {15'd0, mdBusy}, 16'd0);
        chk("rst_stallCnt", stallCnt, 16'd0);
        #1 clrn = 1'b1;
        tick();
    endtask

    initial begin
        clear_in();
        clrn = 1'b0;
        md_left = 0; stall_total = 0;
        #3 check_all();
        chk("reset_pc", {15'd0, pcWrite}, 16'd1);
        @(negedge clk);
        clrn = 1'b1;

        // load-use stall then MEM-stage load forwarding
        set_load_use();
        settle();
        chk("lu_pcWrite", {15'd0, pcWrite}, 16'd0);
        tick();
        clear_in();
        IDrs = 5; IDuseRs = 1; MEMwreg = 1; MEMm2reg = 1; MEMwn = 5;
        settle();
        chk("lu_fwdA", {14'd0, fwdA}, 16'd3);
        chk("lu_stallCnt", stallCnt, 16'd1);
        tick();

        // EX beats MEM; register 0 never forwarded
        clear_in();
        EXwreg = 1; EXwn = 7; MEMwreg = 1; MEMwn = 7; IDrt = 7;
        settle();
        chk("prio_fwdB", {14'd0, fwdB}, 16'd1);
        tick();
        EXwn = 0; IDrs = 0;
        settle();
        chk("r0_fwdA", {14'd0, fwdA}, 16'd0);
        tick();

        // taken branch overrides load-use; untaken falls back to the stall
        clear_in();
        set_load_use();
        EXjumpType = 2'b11; EXbranchTaken = 1;
        settle();
        chk("br_flush", {15'd0, IFIDflush}, 16'd1);
        chk("br_pc", {15'd0, pcWrite}, 16'd1);
        tick();
        EXbranchTaken = 0;
        settle();
        chk("nbr_pc", {15'd0, pcWrite}, 16'd0);
        tick();

        // multiply: four busy cycles from a cleared counter
        clear_in();
        pulse_reset();
        EXmdStart = 1;
        step();
        EXmdStart = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("md_busy", {15'd0, mdBusy}, 16'd1);
            tick();
        end
        settle();
        chk("md_done", {15'd0, mdBusy}, 16'd0);
        chk("md_stallCnt", stallCnt, 16'd4);
        tick();

        // reset in the middle of MDBUSY
        EXmdStart = 1;
        step();
        EXmdStart = 0;
        step();
        step();
        pulse_reset();
        chk("midrst_pc", {15'd0, pcWrite}, 16'd1);

        // randomized traffic with occasional starts and resets
        for (int n = 0; n < 600; n++) begin
            IDrs = 5'($urandom_range(0, 3));
            IDrt = 5'($urandom_range(0, 3));
            EXwn = 5'($urandom_range(0, 3));
            MEMwn = 5'($urandom_range(0, 3));
            {IDuseRs, IDuseRt, EXwreg, EXm2reg, MEMwreg, MEMm2reg} = 6'($urandom);
            EXjumpType = 2'($urandom);
            EXbranchTaken = 1'($urandom);
            EXmdStart = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) pulse_reset();
            else step();
        end

        // saturation of the stall counter
        clear_in();
        set_load_use();
        for (int n = 0; n < 65545; n++) step();
        settle();
        chk("sat_stallCnt", stallCnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
